decoder_mul_arbiter: RTL and testbench

DECODER_MUL_ARBITER -- requirements
Module: decoder_mul_arbiter

---
 rtl/decoder_mul_arbiter.sv | 136 +++++++++++++
 tb/tb_decoder_mul_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_mul_arbiter.sv
// rtl/decoder_mul_arbiter.sv - round-robin arbiter feeding one shared signed x unsigned multiplier
// A one-entry result register drains through a valid/ready handshake.

module decoder_mul_arbiter_mult #(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 5,
  parameter int P_WIDTH = 21
) (
  input  logic signed [A_WIDTH-1:0] a,
  input  logic        [B_WIDTH-1:0] b,
  output logic signed [P_WIDTH-1:0] p
);
  localparam int F_WIDTH = A_WIDTH + B_WIDTH + 1;

  logic signed [B_WIDTH:0]   b_ext;
  logic signed [F_WIDTH-1:0] full;

  // b is zero-extended into a signed operand so the multiply stays signed
  assign b_ext = {1'b0, b};
  assign full  = F_WIDTH'(a) * F_WIDTH'(b_ext);
  assign p     = P_WIDTH'(full);
endmodule

module decoder_mul_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 16,
  parameter int B_WIDTH  = 5,
  parameter int P_WIDTH  = A_WIDTH + B_WIDTH,
  parameter int ID_WIDTH = 2
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]  req_b,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic signed [P_WIDTH-1:0]   res_data,
  output logic [ID_WIDTH-1:0]         res_id,
  output logic [15:0]                 busy_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t                    state;
  logic [ID_WIDTH-1:0]       rr_ptr;
  logic                      can_accept;
  logic                      found;
  logic [ID_WIDTH-1:0]       grant_id;
  logic [NUM_REQ-1:0]        grant_vec;
  logic signed [A_WIDTH-1:0] sel_a;
  logic [B_WIDTH-1:0]        sel_b;
  logic signed [P_WIDTH-1:0] product;
  logic                      xfer;

  // pass-through: a result leaving this cycle frees the register for a new one
  assign can_accept = (state == EMPTY) || res_ready;

  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    grant_id  = '0;
    grant_vec = '0;
    if (ap_rst_n && can_accept) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_REQ;
        if (!found && req_valid[idx]) begin
          found          = 1'b1;
          grant_id       = ID_WIDTH'(idx);
          grant_vec[idx] = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant_vec;
  assign xfer      = found;

  always_comb begin
    sel_a = req_a[int'(grant_id)*A_WIDTH +: A_WIDTH];
    sel_b = req_b[int'(grant_id)*B_WIDTH +: B_WIDTH];
  end

  decoder_mul_arbiter_mult #(
    .A_WIDTH(A_WIDTH),
    .B_WIDTH(B_WIDTH),
    .P_WIDTH(P_WIDTH)
  ) u_mult (
    .a(sel_a),
    .b(sel_b),
    .p(product)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= EMPTY;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (xfer) begin
            state     <= FULL;
            res_valid <= 1'b1;
          end
        end
        FULL: begin
          if (res_ready && !xfer) begin
            state     <= EMPTY;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          res_valid <= 1'b0;
        end
      endcase
      if (xfer) begin
        res_data <= product;
        res_id   <= grant_id;
        rr_ptr   <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      busy_cnt <= '0;
    end else if (res_valid && !res_ready && busy_cnt != 16'hFFFF) begin
      busy_cnt <= busy_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_decoder_mul_arbiter.sv
// tb/tb_decoder_mul_arbiter.sv - directed and random checks of decoder_mul_arbiter against a queue-free reference model

module tb_decoder_mul_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int BW = 5;
  localparam int PW = 21;
  localparam int IW = 2;

  logic                 ap_clk;
  logic                 ap_rst_n;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N*AW-1:0]      req_a;
  logic [N*BW-1:0]      req_b;
  logic                 res_valid;
  logic                 res_ready;
  logic signed [PW-1:0] res_data;
  logic [IW-1:0]        res_id;
  logic [15:0]          busy_cnt;

  int checks;
  int failures;

  // reference model state
  bit     m_full;
  longint m_data;
  int     m_id;
  int     m_ptr;
  int     m_busy;
  int     m_grant;

  decoder_mul_arbiter #(
    .NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .ID_WIDTH(IW)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_id(res_id),
    .busy_cnt(busy_cnt)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_data = 0; m_id = 0; m_ptr = 0; m_busy = 0;
  endtask

  function automatic int model_grant();
    if (m_full && !res_ready) return -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // one clock: check grant before the edge, advance the model, check registers after it
  task automatic cycle(input string tag);
    logic [N-1:0] exp_rdy;
    #1;
    m_grant = model_grant();
    exp_rdy = '0;
    if (m_grant >= 0) exp_rdy[m_grant] = 1'b1;
    chk({tag, ".req_ready"}, 64'(req_ready), 64'(exp_rdy));
    @(posedge ap_clk);
    if (m_full && !res_ready && m_busy < 65535) m_busy++;
    if (m_grant >= 0) begin
      m_data = longint'($signed(req_a[m_grant*AW +: AW])) * longint'(req_b[m_grant*BW +: BW]);
      m_id   = m_grant;
      m_full = 1;
      m_ptr  = (m_grant + 1) % N;
    end else if (m_full && res_ready) begin
      m_full = 0;
    end
    #1;
    chk({tag, ".res_valid"}, 64'(res_valid), 64'(m_full));
    chk({tag, ".res_data"},  64'($signed(res_data)), 64'(m_data));
    chk({tag, ".res_id"},    64'(res_id), 64'(m_id));
    chk({tag, ".busy_cnt"},  64'(busy_cnt), 64'(m_busy));
  endtask

  task automatic set_op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_a[i*AW +: AW] = a;
    req_b[i*BW +: BW] = b;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    ap_rst_n  = 1'b0;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;

    // reset state, no clock edge yet
    #3;
    chk("rst.res_valid", 64'(res_valid), 64'd0);
    chk("rst.res_data",  64'(res_data),  64'd0);
    chk("rst.res_id",    64'(res_id),    64'd0);
    chk("rst.busy_cnt",  64'(busy_cnt),  64'd0);
    chk("rst.req_ready", 64'(req_ready), 64'd0);
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;

    // single request
    req_valid = 4'b0001;
    set_op(0, -16'sd3, 5'd7);
    cycle("single");
    chk("single.value", 64'($signed(res_data)), -64'sd21);

    // all valid, fair rotation with no bubble
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) set_op(i, 16'($urandom), 5'($urandom));
      cycle("rotate");
      chk("rotate.id", 64'(res_id), 64'((c + 1) % N));
    end

    // extremes of the operand ranges
    req_valid = 4'b0001;
    set_op(0, 16'h8000, 5'd31);
    cycle("ext_min");
    chk("ext_min.value", 64'($signed(res_data)), -64'sd1015808);
    set_op(0, 16'h7FFF, 5'd31);
    cycle("ext_max");
    chk("ext_max.value", 64'($signed(res_data)), 64'sd1015777);
    set_op(0, 16'h8000, 5'd0);
    cycle("ext_zero");
    chk("ext_zero.value", 64'($signed(res_data)), 64'sd0);

    // backpressure holds the result and counts stall cycles
    req_valid = 4'b1111;
    res_ready = 1'b0;
    for (int c = 0; c < 5; c++) cycle("stall");
    chk("stall.busy5", 64'(busy_cnt), 64'd5);
    res_ready = 1'b1;
    cycle("release");

    // wrap: move pointer to 3, then alternate 3 / 1
    req_valid = 4'b0100;
    cycle("to_ptr3");
    req_valid = 4'b1010;
    cycle("wrap0");
    chk("wrap0.id", 64'(res_id), 64'd3);
    cycle("wrap1");
    chk("wrap1.id", 64'(res_id), 64'd1);
    cycle("wrap2");
    chk("wrap2.id", 64'(res_id), 64'd3);

    // reset while holding a stalled result
    req_valid = 4'b0000;
    res_ready = 1'b0;
    cycle("pre_rst");
    req_valid = 4'b0110;
    ap_rst_n  = 1'b0;
    #1;
    chk("midrst.res_valid", 64'(res_valid), 64'd0);
    chk("midrst.busy_cnt",  64'(busy_cnt),  64'd0);
    chk("midrst.req_ready", 64'(req_ready), 64'd0);
    model_reset();
    #1;
    ap_rst_n  = 1'b1;
    res_ready = 1'b1;
    cycle("post_rst");
    chk("post_rst.id", 64'(res_id), 64'd1);

    // random traffic
    for (int c = 0; c < 300; c++) begin
      req_valid = 4'($urandom);
      req_a     = {$urandom, $urandom};
      req_b     = 20'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
